// File: rtl/arbitro_pkg.sv
// arbitro_pkg
// Shared definitions for the memory-bus arbiter: requester/source codes,
// default bus widths and the width of the fairness counter.
package arbitro_pkg;

    // Default bus widths
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Fairness counter width (MAX_SEQ_DADOS is limited to 1..15)
    localparam int SEQ_W = 4;

    // Source of a read, also used to tag the returned data
    typedef enum logic [1:0] {
        ORIGEM_INSTR   = 2'b00,
        ORIGEM_DADOS   = 2'b01,
        ORIGEM_ENTRADA = 2'b10
    } origem_e;

endpackage : arbitro_pkg

// File: rtl/arbitro_memoria_seletor_leitura.sv
// seletor_leitura
// Tracks the single in-flight read issued by the arbiter and loads the
// processor's input register one cycle later from the correct source.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   leitura_i         a read (load, fetch or switch read) is granted this cycle
//   origem_i          source of the granted read
//   sw_i              switch value, captured on a switch-read grant
//   ram_instr_q_i     instruction RAM read data
//   ram_dados_q_i     data RAM read data
//   seleciona_o       source of the in-flight read (holds when idle)
//   dado_o            registered read result
//   valido_o          one-cycle pulse: dado_o is new
//   valido_origem_o   source that owns the current dado_o
module seletor_leitura
    import arbitro_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              leitura_i,
    input  origem_e           origem_i,
    input  logic [DATA_W-1:0] sw_i,
    input  logic [DATA_W-1:0] ram_instr_q_i,
    input  logic [DATA_W-1:0] ram_dados_q_i,
    output origem_e           seleciona_o,
    output logic [DATA_W-1:0] dado_o,
    output logic              valido_o,
    output origem_e           valido_origem_o
);

    logic              pendente_q;
    origem_e           sel_q;
    logic [DATA_W-1:0] sw_q;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              valido_q;
    origem_e           origem_q;

    // Source mux for the data arriving one cycle after the grant. The RAMs
    // present their data in this cycle; the switch value was frozen at the
    // grant edge so later switch movement does not leak in.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        dado_d = dado_q;
        if (pendente_q) begin
            unique case (sel_q)
                ORIGEM_INSTR: dado_d = ram_instr_q_i;
                ORIGEM_DADOS: dado_d = ram_dados_q_i;
                default:      dado_d = sw_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pendente_q <= 1'b0;
            sel_q      <= ORIGEM_INSTR;
            sw_q       <= '0;
            dado_q     <= '0;
            valido_q   <= 1'b0;
            origem_q   <= ORIGEM_INSTR;
        end else begin
            // A new read may be granted while one is pending; the pipeline
            // then advances one read per cycle.
            pendente_q <= leitura_i;
            if (leitura_i) begin
                sel_q <= origem_i;
                if (origem_i == ORIGEM_ENTRADA) begin
                    sw_q <= sw_i;
                end
            end
            dado_q   <= dado_d;
            valido_q <= pendente_q;
            if (pendente_q) begin
                origem_q <= sel_q;
            end
        end
    end

    assign seleciona_o     = sel_q;
    assign dado_o          = dado_q;
    assign valido_o        = valido_q;
    assign valido_origem_o = origem_q;

endmodule : seletor_leitura

// File: rtl/arbitro_memoria.sv
// arbitro_memoria
// Arbitrates the shared ADDR/W/Saida bus between instruction fetch,
// data load/store and the switch-input port, and returns read data through
// a latency-tracked path into the processor's input register.
//
// Ports:
//   Clock, Resetn                 clock, asynchronous active-low reset
//   ReqInstr/AddrInstr            fetch request and address
//   ReqDados/WeDados/AddrDados/WDados  load/store request
//   ReqEntrada/SW                 switch-read request and switch value
//   RamInstrQ/RamDadosQ           RAM read data, one cycle after address
//   GntInstr/GntDados/GntEntrada  one-cycle, mutually exclusive grants
//   ADDR/W/Saida                  shared RAM address, write enable, write data
//   SelecionaMemoria              source of the in-flight read
//   DadoEntrada/Valido/ValidoOrigem  registered read result and tag
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_SEQ_DADOS = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              ReqInstr,
    input  logic [ADDR_W-1:0] AddrInstr,
    input  logic              ReqDados,
    input  logic              WeDados,
    input  logic [ADDR_W-1:0] AddrDados,
    input  logic [DATA_W-1:0] WDados,
    input  logic              ReqEntrada,
    input  logic [DATA_W-1:0] SW,
    input  logic [DATA_W-1:0] RamInstrQ,
    input  logic [DATA_W-1:0] RamDadosQ,
    output logic              GntInstr,
    output logic              GntDados,
    output logic              GntEntrada,
    output logic [ADDR_W-1:0] ADDR,
    output logic              W,
    output logic [DATA_W-1:0] Saida,
    output logic [1:0]        SelecionaMemoria,
    output logic [DATA_W-1:0] DadoEntrada,
    output logic              Valido,
    output logic [1:0]        ValidoOrigem
);

    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(MAX_SEQ_DADOS);

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic    gnt_instr, gnt_dados, gnt_entrada;
    logic    dados_ok;
    logic    leitura;
    origem_e origem;
    origem_e sel_leitura, valido_origem;

    // Grant priority: data port first, unless it has used up its run of
    // consecutive grants while fetch is waiting; then fetch; then switches.
    // Grants are also masked by Resetn so the bus is quiet during reset.
    always_comb begin
        dados_ok    = ReqDados && !((seq_q == SEQ_MAX) && ReqInstr);
        gnt_dados   = 1'b0;
        gnt_instr   = 1'b0;
        gnt_entrada = 1'b0;
        if (Resetn) begin
            if (dados_ok) begin
                gnt_dados = 1'b1;
            end else if (ReqInstr) begin
                gnt_instr = 1'b1;
            end else if (ReqEntrada) begin
                gnt_entrada = 1'b1;
            end
        end
    end

    // Bus drive. A switch read has no RAM address, so ADDR holds like idle.
    always_comb begin
        addr_d = addr_q;
        if (gnt_dados) begin
            addr_d = AddrDados;
        end else if (gnt_instr) begin
            addr_d = AddrInstr;
        end
    end

    assign ADDR  = addr_d;
    assign W     = gnt_dados && WeDados;
    assign Saida = (gnt_dados && WeDados) ? WDados : '0;

    // Read grant and its source code for the return path
    always_comb begin
        leitura = (gnt_dados && !WeDados) || gnt_instr || gnt_entrada;
        origem  = ORIGEM_INSTR;
        if (gnt_dados) begin
            origem = ORIGEM_DADOS;
        end else if (gnt_entrada) begin
            origem = ORIGEM_ENTRADA;
        end
    end

    // Fairness counter: counts data grants made while fetch is waiting.
    always_comb begin
        seq_d = seq_q;
        if (gnt_instr || !ReqInstr) begin
            seq_d = '0;
        end else if (gnt_dados && (seq_q < SEQ_MAX)) begin
            seq_d = seq_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            seq_q  <= '0;
            addr_q <= '0;
        end else begin
            seq_q  <= seq_d;
            addr_q <= addr_d;
        end
    end

    assign GntInstr   = gnt_instr;
    assign GntDados   = gnt_dados;
    assign GntEntrada = gnt_entrada;

    seletor_leitura #(
        .DATA_W (DATA_W)
    ) u_seletor_leitura (
        .clk_i           (Clock),
        .rst_n_i         (Resetn),
        .leitura_i       (leitura),
        .origem_i        (origem),
        .sw_i            (SW),
        .ram_instr_q_i   (RamInstrQ),
        .ram_dados_q_i   (RamDadosQ),
        .seleciona_o     (sel_leitura),
        .dado_o          (DadoEntrada),
        .valido_o        (Valido),
        .valido_origem_o (valido_origem)
    );

    assign SelecionaMemoria = sel_leitura;
    assign ValidoOrigem     = valido_origem;

endmodule : arbitro_memoria

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria
// Self-checking bench: a requester model with per-port transaction queues,
// a reference arbiter model and a scoreboard of expected read returns.
module tb_arbitro_memoria;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXS = 3;

    logic          Clock, Resetn;
    logic          ReqInstr, ReqDados, WeDados, ReqEntrada;
    logic [AW-1:0] AddrInstr, AddrDados;
    logic [DW-1:0] WDados, SW, RamInstrQ, RamDadosQ;
    logic          GntInstr, GntDados, GntEntrada, W, Valido;
    logic [AW-1:0] ADDR;
    logic [DW-1:0] Saida, DadoEntrada;
    logic [1:0]    SelecionaMemoria, ValidoOrigem;

    arbitro_memoria #(
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .MAX_SEQ_DADOS (MAXS)
    ) dut (
        .Clock            (Clock),
        .Resetn           (Resetn),
        .ReqInstr         (ReqInstr),
        .AddrInstr        (AddrInstr),
        .ReqDados         (ReqDados),
        .WeDados          (WeDados),
        .AddrDados        (AddrDados),
        .WDados           (WDados),
        .ReqEntrada       (ReqEntrada),
        .SW               (SW),
        .RamInstrQ        (RamInstrQ),
        .RamDadosQ        (RamDadosQ),
        .GntInstr         (GntInstr),
        .GntDados         (GntDados),
        .GntEntrada       (GntEntrada),
        .ADDR             (ADDR),
        .W                (W),
        .Saida            (Saida),
        .SelecionaMemoria (SelecionaMemoria),
        .DadoEntrada      (DadoEntrada),
        .Valido           (Valido),
        .ValidoOrigem     (ValidoOrigem)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // RAM contents: explicit entries, otherwise a fixed address pattern
    logic [DW-1:0] mem_i [logic [AW-1:0]];
    logic [DW-1:0] mem_d [logic [AW-1:0]];

    function automatic logic [DW-1:0] rd_i(input logic [AW-1:0] a);
        if (mem_i.exists(a)) return mem_i[a];
        return a ^ 16'h5A00;
    endfunction

    function automatic logic [DW-1:0] rd_d(input logic [AW-1:0] a);
        if (mem_d.exists(a)) return mem_d[a];
        return a ^ 16'hC300;
    endfunction

    // Synchronous-read RAMs: address registered on the clock edge
    always @(posedge Clock) begin
        RamInstrQ <= rd_i(ADDR);
        RamDadosQ <= rd_d(ADDR);
    end

    // Stimulus queues per requester
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } dados_t;

    typedef struct {
        int            due;
        logic [1:0]    org;
        logic [DW-1:0] data;
    } sb_t;

    logic [AW-1:0] q_instr[$];
    dados_t        q_dados[$];
    logic [DW-1:0] q_sw[$];
    logic [DW-1:0] sw_idle;
    sb_t           sb[$];
    int            rec[$];
    bit            rec_en;

    // Reference model state
    int            cyc;
    int            seq_m;
    logic [AW-1:0] last_addr_m;
    logic [1:0]    sel_m;
    logic [1:0]    org_m;
    logic [DW-1:0] dado_m;

    int n_asserts;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        ReqInstr = (q_instr.size() > 0);
        if (ReqInstr) AddrInstr = q_instr[0];
        ReqDados = (q_dados.size() > 0);
        if (ReqDados) begin
            WeDados   = q_dados[0].we;
            AddrDados = q_dados[0].addr;
            WDados    = q_dados[0].wd;
        end else begin
            WeDados = 1'b0;
        end
        ReqEntrada = (q_sw.size() > 0);
        SW         = ReqEntrada ? q_sw[0] : sw_idle;
    endtask

    task automatic reset_model();
        sb.delete();
        seq_m       = 0;
        last_addr_m = '0;
        sel_m       = 2'b00;
        org_m       = 2'b00;
        dado_m      = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, {GntInstr, GntDados, GntEntrada}, 3'b000);
        check({tag, "_addr"}, ADDR, 16'h0000);
        check({tag, "_w"}, W, 1'b0);
        check({tag, "_saida"}, Saida, 16'h0000);
        check({tag, "_sel"}, SelecionaMemoria, 2'b00);
        check({tag, "_dado"}, DadoEntrada, 16'h0000);
        check({tag, "_valido"}, Valido, 1'b0);
        check({tag, "_origem"}, ValidoOrigem, 2'b00);
    endtask

    // One clock cycle: check at the falling edge, advance the model on the
    // rising edge, then present the next requests.
    task automatic step();
        logic          ei, ed, ee, est, exp_v;
        logic [AW-1:0] ea;
        @(negedge Clock);
        ed  = ReqDados && !((seq_m == MAXS) && ReqInstr);
        ei  = !ed && ReqInstr;
        ee  = !ed && !ei && ReqEntrada;
        est = ed && q_dados[0].we;
        ea  = last_addr_m;
        if (ed) ea = q_dados[0].addr;
        else if (ei) ea = q_instr[0];

        check("gnt", {GntInstr, GntDados, GntEntrada}, {ei, ed, ee});
        check("addr", ADDR, ea);
        check("w", W, est);
        if (est) check("saida", Saida, q_dados[0].wd);
        check("sel", SelecionaMemoria, sel_m);
        if (rec_en && (GntInstr || GntDados || GntEntrada))
            rec.push_back(GntDados ? 1 : (GntInstr ? 0 : 2));

        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        if (exp_v) begin
            dado_m = sb[0].data;
            org_m  = sb[0].org;
            void'(sb.pop_front());
        end
        check("valido", Valido, exp_v);
        check("dado", DadoEntrada, dado_m);
        check("origem", ValidoOrigem, org_m);

        if (ei) sb.push_back('{cyc + 2, 2'b00, rd_i(ea)});
        if (ed && !est) sb.push_back('{cyc + 2, 2'b01, rd_d(ea)});
        if (ee) sb.push_back('{cyc + 2, 2'b10, q_sw[0]});

        @(posedge Clock);
        cyc++;
        last_addr_m = ea;
        if (ei) sel_m = 2'b00;
        else if (ed && !est) sel_m = 2'b01;
        else if (ee) sel_m = 2'b10;
        if (ei || !ReqInstr) seq_m = 0;
        else if (ed && seq_m < MAXS) seq_m++;
        if (ei) void'(q_instr.pop_front());
        if (ed) void'(q_dados.pop_front());
        if (ee) void'(q_sw.pop_front());
        #1;
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_instr.size() + q_dados.size() + q_sw.size() + sb.size()) > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_left", q_instr.size() + q_dados.size() + q_sw.size() + sb.size(), 0);
        step();
    endtask

    initial begin
        int pat_fair[8];
        int pat_all[3];
        pat_fair = '{1, 1, 1, 0, 1, 1, 1, 0};
        pat_all  = '{1, 0, 2};
        n_asserts = 0;
        n_fail    = 0;
        cyc       = 0;
        rec_en    = 1'b0;
        sw_idle   = 16'h0000;
        AddrInstr = '0;
        AddrDados = '0;
        WDados    = '0;
        mem_i[16'h0004] = 16'h1234;
        mem_i[16'h0003] = 16'hA5A5;
        mem_d[16'h0001] = 16'h0011;
        mem_d[16'h0002] = 16'h0022;
        reset_model();

        // Reset state
        Resetn = 1'b0;
        drive();
        #12;
        check_reset_outputs("rst");
        @(negedge Clock);
        Resetn = 1'b1;
        step();

        // Reset mid-read: fetch granted, reset before the return edge
        q_instr.push_back(16'h0004);
        drive();
        step();
        #2;
        Resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        reset_model();
        @(negedge Clock);
        Resetn = 1'b1;
        repeat (4) step();

        // Single fetch
        q_instr.push_back(16'h0003);
        drive();
        drain();
        check("fetch_dado", DadoEntrada, 16'hA5A5);

        // Store
        q_dados.push_back('{1'b1, 16'h0010, 16'hBEEF});
        drive();
        drain();
        repeat (2) step();

        // Fairness: fetch and loads held together
        rec.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q_instr.push_back(16'h0100 + 16'(i));
            q_dados.push_back('{1'b0, 16'h0200 + 16'(i), 16'h0000});
        end
        drive();
        drain();
        rec_en = 1'b0;
        for (int i = 0; i < 8; i++)
            check($sformatf("fair_seq%0d", i), (rec.size() > i) ? rec[i] : 3, pat_fair[i]);

        // Switch read: SW moves after the grant
        sw_idle = 16'h1111;
        q_sw.push_back(16'h00FF);
        drive();
        drain();
        check("entrada_dado", DadoEntrada, 16'h00FF);
        check("entrada_origem", ValidoOrigem, 2'b10);

        // All three requesters together
        rec.delete();
        rec_en = 1'b1;
        q_instr.push_back(16'h0030);
        q_dados.push_back('{1'b0, 16'h0031, 16'h0000});
        q_sw.push_back(16'h2222);
        drive();
        drain();
        rec_en = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("all3_seq%0d", i), (rec.size() > i) ? rec[i] : 3, pat_all[i]);

        // Back-to-back loads
        q_dados.push_back('{1'b0, 16'h0001, 16'h0000});
        q_dados.push_back('{1'b0, 16'h0002, 16'h0000});
        drive();
        drain();
        check("b2b_last", DadoEntrada, 16'h0022);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule : tb_arbitro_memoria
